// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue slice: word and ALU-function types, MIPS
// opcode/funct encodings, and the issue record produced by decode.
package common;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        FUNC_ADD = 3'd0,
        FUNC_SUB = 3'd1,
        FUNC_AND = 3'd2,
        FUNC_OR  = 3'd3,
        FUNC_NOR = 3'd4,
        FUNC_SLT = 3'd5
    } func_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef struct packed {
        func_t func;
        word_t op_a;
        word_t op_b;
        logic  illegal;
    } issue_t;

    // Value the outputs show whenever no entry is held.
    localparam issue_t ISSUE_NONE = '{func: FUNC_ADD, op_a: '0, op_b: '0, illegal: 1'b0};

    function automatic word_t sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic word_t zext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS decode: raw instruction plus register operands to an
// issue record. Unknown encodings become an illegal add of zeros.
module alu_decode
    import common::*;
(
    input  word_t  instr,
    input  word_t  rs_data,
    input  word_t  rt_data,
    output issue_t rec
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm16;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves
        // rec unassigned, which would otherwise infer a latch.
        rec = ISSUE_NONE;
        unique case (opcode)
            OP_RTYPE: begin
                rec.op_a = rs_data;
                rec.op_b = rt_data;
                unique case (funct)
                    FN_ADD, FN_ADDU: rec.func = FUNC_ADD;
                    FN_SUB, FN_SUBU: rec.func = FUNC_SUB;
                    FN_AND:          rec.func = FUNC_AND;
                    FN_OR:           rec.func = FUNC_OR;
                    FN_NOR:          rec.func = FUNC_NOR;
                    FN_SLT:          rec.func = FUNC_SLT;
                    default:         rec = '{func: FUNC_ADD, op_a: '0, op_b: '0, illegal: 1'b1};
                endcase
            end
            OP_BEQ, OP_BNE: begin
                rec.func = FUNC_SUB;
                rec.op_a = rs_data;
                rec.op_b = rt_data;
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
                rec.func = FUNC_ADD;
                rec.op_a = rs_data;
                rec.op_b = sext16(imm16);
            end
            OP_SLTI: begin
                rec.func = FUNC_SLT;
                rec.op_a = rs_data;
                rec.op_b = sext16(imm16);
            end
            OP_ANDI: begin
                rec.func = FUNC_AND;
                rec.op_a = rs_data;
                rec.op_b = zext16(imm16);
            end
            OP_ORI: begin
                rec.func = FUNC_OR;
                rec.op_a = rs_data;
                rec.op_b = zext16(imm16);
            end
            default: rec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Single registered issue stage: valid/ready handshake around alu_decode,
// with flush and a saturating count of accepted illegal instructions.
module alu_issue
    import common::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  word_t      instr,
    input  word_t      rs_data,
    input  word_t      rt_data,
    input  logic       flush,
    output logic       out_valid,
    input  logic       out_ready,
    output func_t      alu_func,
    output word_t      op_a,
    output word_t      op_b,
    output logic       illegal,
    output logic [7:0] illegal_cnt
);

    issue_t     dec_rec;
    issue_t     rec_q, rec_d;
    logic       valid_q, valid_d;
    logic [7:0] cnt_q, cnt_d;
    logic       accept;

    alu_decode u_decode (
        .instr   (instr),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .rec     (dec_rec)
    );

    assign in_ready = (!valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        rec_d   = rec_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            rec_d   = ISSUE_NONE;
        end else if (accept) begin
            valid_d = 1'b1;
            rec_d   = dec_rec;
            if (dec_rec.illegal && cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
        end else if (out_ready) begin
            // Consumed with nothing behind it: drop back to the idle record.
            valid_d = 1'b0;
            rec_d   = ISSUE_NONE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            rec_q   <= ISSUE_NONE;
            cnt_q   <= 8'h00;
        end else begin
            valid_q <= valid_d;
            rec_q   <= rec_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign alu_func    = rec_q.func;
    assign op_a        = rec_q.op_a;
    assign op_b        = rec_q.op_b;
    assign illegal     = rec_q.illegal;
    assign illegal_cnt = cnt_q;

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL use one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 Ports, clock and reset first:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  instruction and operands present
- in_ready  out  1  block accepts the current instruction
- instr  in  word_t  raw 32-bit MIPS instruction
- rs_data  in  word_t  register-file value for rs
- rt_data  in  word_t  register-file value for rt
- flush  in  1  discard the held entry this cycle
- out_valid  out  1  issued ALU operation valid
- out_ready  in  1  EX stage consumes the issued operation
- alu_func  out  common::func_t  operation for the ALU
- op_a  out  word_t  ALU operand a
- op_b  out  word_t  ALU operand b
- illegal  out  1  held entry is an undecodable instruction
- illegal_cnt  out  8  saturating count of accepted illegal instructions

Function
REQ-003 The block SHALL be a single registered issue stage; an accepted instruction appears on the outputs the cycle after acceptance (latency 1).
REQ-004 Accept SHALL occur when in_valid and in_ready are both 1; in_ready SHALL equal (!out_valid || out_ready) && !flush.
REQ-005 Held outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-006 Same-cycle out_ready=1 and accept SHALL replace the entry with no bubble.
REQ-007 flush=1 SHALL clear out_valid next cycle, override any accept and any held entry.
REQ-008 R-type (opcode 0x00) funct decode: 0x20/0x21 add, 0x22/0x23 sub, 0x24 land, 0x25 lor, 0x27 lnor, 0x2A slt; op_a=rs_data, op_b=rt_data.
REQ-009 I-type: 0x08/0x09 add, 0x0A slt, 0x23 (lw) and 0x2B (sw) add with sign-extended imm16; 0x0C land, 0x0D lor with zero-extended imm16; op_a=rs_data.
REQ-010 Opcode 0x04 (beq) and 0x05 (bne) SHALL issue sub with op_a=rs_data, op_b=rt_data.
REQ-011 Any other opcode/funct SHALL be issued with alu_func=add, op_a=op_b=0, illegal=1; out_valid still asserts so the pipeline observes it.
REQ-012 illegal_cnt SHALL increment on each accepted illegal instruction and saturate at 0xFF; flush SHALL not decrement it.
REQ-013 When out_valid=0, alu_func, op_a, op_b, illegal SHALL read add, 0, 0, 0.

Reset
REQ-014 Asserting rst at any time SHALL immediately force out_valid=0, alu_func=add, op_a=0, op_b=0, illegal=0, illegal_cnt=0; a held entry is lost.
REQ-015 in_ready SHALL be 1 in the first cycle after rst deasserts (absent flush).

Structure
REQ-016 Opcode and funct encodings as named constants, and an issue-record struct (func, op_a, op_b, illegal), SHALL live in package common beside func_t and word_t.
REQ-017 Decode SHALL be a combinational sub-module alu_decode (instr, rs_data, rt_data -> issue record); alu_issue holds the register stage, handshake and counter.

Verification
REQ-018 add $3,$1,$2 (0x00221820), rs_data=5, rt_data=7, out_ready=1 -> next cycle out_valid=1, alu_func=add, op_a=5, op_b=7.
REQ-019 addi 0x20218000, rs_data=0x10 -> op_b=0xFFFF8000, alu_func=add; andi 0x3021FFFF -> op_b=0x0000FFFF, alu_func=land.
REQ-020 Issue slt 0x0022182A, hold out_ready=0 three cycles while presenting a second instruction -> outputs stable, in_ready=0; out_ready=1 -> second instruction issued the next cycle, none dropped or duplicated.
REQ-021 Held entry with out_ready=0 and flush=1 plus in_valid=1 -> out_valid=0 next cycle, new instruction not accepted.
REQ-022 Issue 300 instructions with opcode 0x3F -> illegal=1 on each, illegal_cnt ends at 0xFF.
REQ-023 Assert rst mid-cycle with a held entry and illegal_cnt=4 -> outputs zero immediately without a clock edge, illegal_cnt=0.
